// File: rtl/pifo_deq_ctrl.sv
// ============================================================================
// Module   : pifo_deq_ctrl
// Purpose  : Paced PIFO dequeue controller feeding a small output FIFO that
//            drives a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pifo_deq_ctrl #(
   parameter int RANK_WIDTH   = 8,
   parameter int META_WIDTH   = 8,
   parameter int L2_BUF_DEPTH = 1,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    deq_en,
   input  logic                    pifo_valid,
   input  logic [RANK_WIDTH-1:0]   pifo_rank,
   input  logic [META_WIDTH-1:0]   pifo_meta,
   output logic                    pifo_remove,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [RANK_WIDTH-1:0]   m_rank,
   output logic [META_WIDTH-1:0]   m_meta,
   output logic [L2_BUF_DEPTH:0]   buf_count,
   output logic [CNT_WIDTH-1:0]    deq_count
);

   localparam int                  c_depth_n = 2 ** L2_BUF_DEPTH;
   localparam logic [L2_BUF_DEPTH:0] c_depth = (L2_BUF_DEPTH + 1)'(c_depth_n);

   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_hold = 1'b1;

   logic [0:0]              r_state;
   logic [0:0]              w_state_nxt;
   logic                    w_remove;
   logic                    w_read;
   logic                    w_full;

   logic [RANK_WIDTH-1:0]   r_rank_mem [c_depth_n];
   logic [META_WIDTH-1:0]   r_meta_mem [c_depth_n];
   logic [L2_BUF_DEPTH-1:0] r_wr_ptr;
   logic [L2_BUF_DEPTH-1:0] r_rd_ptr;
   logic [L2_BUF_DEPTH:0]   r_count;
   logic [CNT_WIDTH-1:0]    r_deq_cnt;

   // Full check deliberately ignores a same-cycle read.
   assign w_full = (r_count == c_depth);
   assign w_read = m_valid & m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: if (pifo_valid && deq_en && !w_full) w_state_nxt = c_st_hold;
         c_st_hold: w_state_nxt = c_st_idle;
         default:   w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      w_remove = 1'b0;
      if (r_state == c_st_idle && pifo_valid && deq_en && !w_full) begin
         w_remove = 1'b1;
      end
   end

   // Gated with rst_n so the Mealy pulse is silent while reset is held.
   assign pifo_remove = w_remove & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_depth_n; i++) begin
            r_rank_mem[i] <= '0;
            r_meta_mem[i] <= '0;
         end
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_deq_cnt <= '0;
      end else begin
         if (w_remove) begin
            r_rank_mem[r_wr_ptr] <= pifo_rank;
            r_meta_mem[r_wr_ptr] <= pifo_meta;
            r_wr_ptr             <= r_wr_ptr + L2_BUF_DEPTH'(1);
            r_deq_cnt            <= r_deq_cnt + CNT_WIDTH'(1);
         end
         if (w_read) begin
            r_rd_ptr <= r_rd_ptr + L2_BUF_DEPTH'(1);
         end
         case ({w_remove, w_read})
            2'b10:   r_count <= r_count + (L2_BUF_DEPTH + 1)'(1);
            2'b01:   r_count <= r_count - (L2_BUF_DEPTH + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign m_valid   = (r_count != '0);
   assign m_rank    = r_rank_mem[r_rd_ptr];
   assign m_meta    = r_meta_mem[r_rd_ptr];
   assign buf_count = r_count;
   assign deq_count = r_deq_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pifo_deq_ctrl.sv
// ============================================================================
// Module   : tb_pifo_deq_ctrl
// Purpose  : Directed self-checking bench for pifo_deq_ctrl with a small
//            behavioural PIFO upstream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pifo_deq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       deq_en;
   logic       pifo_valid;
   logic [7:0] pifo_rank;
   logic [7:0] pifo_meta;
   logic       pifo_remove;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_rank;
   logic [7:0] m_meta;
   logic [1:0] buf_count;
   logic [31:0] deq_count;

   pifo_deq_ctrl #(
      .RANK_WIDTH  (8),
      .META_WIDTH  (8),
      .L2_BUF_DEPTH(1),
      .CNT_WIDTH   (32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .deq_en     (deq_en),
      .pifo_valid (pifo_valid),
      .pifo_rank  (pifo_rank),
      .pifo_meta  (pifo_meta),
      .pifo_remove(pifo_remove),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_rank     (m_rank),
      .m_meta     (m_meta),
      .buf_count  (buf_count),
      .deq_count  (deq_count)
   );

   always #5 clk = ~clk;

   // Behavioural PIFO: unsorted store, combinational min, registered valid
   // that drops for one cycle after each remove.
   logic       ins_v;
   logic [7:0] ins_r;
   logic [7:0] ins_m;
   logic [7:0] pm_rank [8];
   logic [7:0] pm_meta [8];
   logic [3:0] pm_n;
   logic       pm_valid;
   logic [2:0] w_min_idx;
   logic [2:0] w_last;
   logic [2:0] w_ins_idx;

   always_comb begin
      w_min_idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (4'(i) < pm_n && pm_rank[i] < pm_rank[w_min_idx]) w_min_idx = 3'(i);
      end
   end

   assign w_last     = 3'(pm_n - 4'd1);
   assign w_ins_idx  = 3'(pm_n - 4'(pifo_remove));
   assign pifo_valid = pm_valid;
   assign pifo_rank  = pm_rank[w_min_idx];
   assign pifo_meta  = pm_meta[w_min_idx];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pm_n     <= 4'd0;
         pm_valid <= 1'b0;
      end else begin
         if (pifo_remove) begin
            pm_rank[w_min_idx] <= pm_rank[w_last];
            pm_meta[w_min_idx] <= pm_meta[w_last];
         end
         if (ins_v) begin
            pm_rank[w_ins_idx] <= ins_r;
            pm_meta[w_ins_idx] <= ins_m;
         end
         pm_n     <= pm_n - 4'(pifo_remove) + 4'(ins_v);
         pm_valid <= !pifo_remove && ((pm_n - 4'(pifo_remove) + 4'(ins_v)) != 4'd0);
      end
   end

   // Monitors: remove pulses, back-to-back pulses, and stream transfers.
   int         rem_pulses = 0;
   int         b2b        = 0;
   logic       prev_rem   = 1'b0;
   int         out_n      = 0;
   logic [7:0] out_rank [64];
   logic [7:0] out_meta [64];

   always @(posedge clk) begin
      if (rst_n) begin
         rem_pulses <= rem_pulses + int'(pifo_remove);
         if (prev_rem && pifo_remove) b2b <= b2b + 1;
         prev_rem <= pifo_remove;
         if (m_valid && m_ready) begin
            out_rank[out_n] <= m_rank;
            out_meta[out_n] <= m_meta;
            out_n           <= out_n + 1;
         end
      end else begin
         prev_rem <= 1'b0;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] r, input logic [7:0] m);
      ins_v = 1'b1;
      ins_r = r;
      ins_m = m;
      @(negedge clk);
      ins_v = 1'b0;
   endtask

   int p0;
   int o0;

   initial begin
      rst_n   = 1'b0;
      deq_en  = 1'b0;
      m_ready = 1'b0;
      ins_v   = 1'b0;
      ins_r   = 8'd0;
      ins_m   = 8'd0;

      // Reset state
      tick(2);
      check("rst_remove", 64'(pifo_remove), 64'd0);
      check("rst_mvalid", 64'(m_valid), 64'd0);
      check("rst_mrank", 64'(m_rank), 64'd0);
      check("rst_mmeta", 64'(m_meta), 64'd0);
      check("rst_bufcnt", 64'(buf_count), 64'd0);
      check("rst_deqcnt", 64'(deq_count), 64'd0);
      rst_n = 1'b1;
      tick(1);

      // Single entry
      m_ready = 1'b1;
      p0 = rem_pulses;
      o0 = out_n;
      push(8'd5, 8'hA1);
      deq_en = 1'b1;
      #1;
      check("single_remove", 64'(pifo_remove), 64'd1);
      @(negedge clk);
      check("single_mvalid", 64'(m_valid), 64'd1);
      check("single_mrank", 64'(m_rank), 64'd5);
      check("single_mmeta", 64'(m_meta), 64'hA1);
      check("single_hold_noremove", 64'(pifo_remove), 64'd0);
      check("single_deqcnt", 64'(deq_count), 64'd1);
      tick(3);
      check("single_pulses", 64'(rem_pulses - p0), 64'd1);
      check("single_xfers", 64'(out_n - o0), 64'd1);
      check("single_bufcnt", 64'(buf_count), 64'd0);

      // Sorted drain
      deq_en = 1'b0;
      p0 = rem_pulses;
      o0 = out_n;
      push(8'd9, 8'h19);
      push(8'd3, 8'h13);
      push(8'd7, 8'h17);
      push(8'd1, 8'h11);
      deq_en = 1'b1;
      tick(12);
      check("sort_xfers", 64'(out_n - o0), 64'd4);
      check("sort_0", 64'(out_rank[o0]), 64'd1);
      check("sort_1", 64'(out_rank[o0+1]), 64'd3);
      check("sort_2", 64'(out_rank[o0+2]), 64'd7);
      check("sort_3", 64'(out_rank[o0+3]), 64'd9);
      check("sort_meta0", 64'(out_meta[o0]), 64'h11);
      check("sort_pulses", 64'(rem_pulses - p0), 64'd4);
      check("sort_deqcnt", 64'(deq_count), 64'd5);

      // Backpressure with depth 2, then read/write at full
      m_ready = 1'b0;
      deq_en  = 1'b0;
      p0 = rem_pulses;
      o0 = out_n;
      push(8'd4, 8'h24);
      push(8'd2, 8'h22);
      push(8'd8, 8'h28);
      push(8'd6, 8'h26);
      deq_en = 1'b1;
      tick(10);
      check("bp_pulses", 64'(rem_pulses - p0), 64'd2);
      check("bp_bufcnt", 64'(buf_count), 64'd2);
      check("bp_mvalid", 64'(m_valid), 64'd1);
      check("bp_mrank", 64'(m_rank), 64'd2);
      check("bp_mmeta", 64'(m_meta), 64'h22);
      check("bp_noremove", 64'(pifo_remove), 64'd0);
      tick(1);
      check("bp_stable", 64'(m_rank), 64'd2);
      m_ready = 1'b1;
      #1;
      check("full_rd_noremove", 64'(pifo_remove), 64'd0);
      @(negedge clk);
      check("full_buf_1", 64'(buf_count), 64'd1);
      check("full_remove_next", 64'(pifo_remove), 64'd1);
      m_ready = 1'b0;
      @(negedge clk);
      check("full_buf_2", 64'(buf_count), 64'd2);
      m_ready = 1'b1;
      tick(10);
      check("bp_xfers", 64'(out_n - o0), 64'd4);
      check("bp_0", 64'(out_rank[o0]), 64'd2);
      check("bp_1", 64'(out_rank[o0+1]), 64'd4);
      check("bp_2", 64'(out_rank[o0+2]), 64'd6);
      check("bp_3", 64'(out_rank[o0+3]), 64'd8);
      check("bp_meta3", 64'(out_meta[o0+3]), 64'h28);
      check("bp_deqcnt", 64'(deq_count), 64'd9);
      check("bp_drained", 64'(buf_count), 64'd0);

      // Pause
      deq_en = 1'b0;
      p0 = rem_pulses;
      o0 = out_n;
      push(8'd5, 8'h35);
      push(8'd1, 8'h31);
      push(8'd3, 8'h33);
      tick(6);
      check("pause_pulses", 64'(rem_pulses - p0), 64'd0);
      deq_en = 1'b1;
      #1;
      check("pause_one_remove", 64'(pifo_remove), 64'd1);
      @(negedge clk);
      deq_en = 1'b0;
      tick(6);
      check("pause_pulses_1", 64'(rem_pulses - p0), 64'd1);
      check("pause_deqcnt", 64'(deq_count), 64'd10);
      check("pause_rank", 64'(out_rank[o0]), 64'd1);

      // Asynchronous reset in HOLD with one buffered entry
      m_ready = 1'b0;
      deq_en  = 1'b1;
      @(negedge clk);
      deq_en = 1'b0;
      check("ar_pre_bufcnt", 64'(buf_count), 64'd1);
      check("ar_pre_mrank", 64'(m_rank), 64'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_remove", 64'(pifo_remove), 64'd0);
      check("ar_mvalid", 64'(m_valid), 64'd0);
      check("ar_mrank", 64'(m_rank), 64'd0);
      check("ar_mmeta", 64'(m_meta), 64'd0);
      check("ar_bufcnt", 64'(buf_count), 64'd0);
      check("ar_deqcnt", 64'(deq_count), 64'd0);
      tick(2);
      rst_n   = 1'b1;
      deq_en  = 1'b1;
      m_ready = 1'b1;
      p0 = rem_pulses;
      o0 = out_n;
      push(8'd7, 8'h77);
      tick(4);
      check("ar_resume_deqcnt", 64'(deq_count), 64'd1);
      check("ar_resume_pulses", 64'(rem_pulses - p0), 64'd1);
      check("ar_resume_rank", 64'(out_rank[o0]), 64'd7);
      check("ar_resume_meta", 64'(out_meta[o0]), 64'h77);
      check("ar_resume_bufcnt", 64'(buf_count), 64'd0);

      check("no_back_to_back", 64'(b2b), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pifo_deq_ctrl.md
# pifo_deq_ctrl

Dequeue controller that sits directly downstream of the PIFO register block. It watches the PIFO's registered min-valid flag, issues single-cycle remove pulses, and captures the head rank/meta presented on the same cycle as each pulse. Captured entries go into a small output FIFO that drives a valid/ready stream toward the output scheduler/packet fetch stage. The block enforces the PIFO's two-cycle min-recompute window, never over-commits its buffer, and honours a pause input from the scheduler.

## Interface
Parameters:
- RANK_WIDTH, 8, rank width; must match the PIFO.
- META_WIDTH, 8, metadata width; must match the PIFO.
- L2_BUF_DEPTH, 1, log2 of output FIFO depth (depth = 2**L2_BUF_DEPTH, at least 2).
- CNT_WIDTH, 32, width of the dequeue statistics counter.

Ports:
- clk  in  1  sole clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- deq_en  in  1  1 permits new removals; 0 pauses issuing (the output stream still drains).
- pifo_valid  in  1  PIFO min-valid (registered); head entry is meaningful when 1.
- pifo_rank  in  RANK_WIDTH  PIFO head rank (combinational from PIFO).
- pifo_meta  in  META_WIDTH  PIFO head metadata.
- pifo_remove  out  1  single-cycle remove pulse to the PIFO.
- m_valid  out  1  output entry available.
- m_ready  in  1  consumer accepts; transfer happens when m_valid & m_ready.
- m_rank  out  RANK_WIDTH  output rank.
- m_meta  out  META_WIDTH  output metadata.
- buf_count  out  L2_BUF_DEPTH+1  occupancy of the output FIFO.
- deq_count  out  CNT_WIDTH  total removals issued; wraps modulo 2**CNT_WIDTH.

## Operation
- FSM states:
  - IDLE: waiting for a removal to become legal.
  - HOLD: post-remove blanking.
- IDLE to HOLD when pifo_valid & deq_en & (buf_count < depth). On that cycle:
  - pifo_remove = 1.
  - pifo_rank/pifo_meta are written into the FIFO at the edge.
  - deq_count increments.
- HOLD to IDLE unconditionally after one cycle. pifo_remove = 0 in HOLD, and pifo_valid is ignored.
- HOLD covers the cycle where the PIFO's min tree and valid are being recomputed. The PIFO's valid_out drops one cycle after the remove and can reassert the cycle after that. HOLD prevents a double remove on stale data.
- pifo_remove is a registered-free Mealy output: it is asserted combinationally in IDLE from current inputs. It is never asserted two consecutive cycles.
- Output FIFO: circular buffer with write/read pointers and an occupancy counter.
  - m_valid = (buf_count != 0).
  - m_rank/m_meta come from the read pointer.
  - Pointers wrap at depth.
- Simultaneous write and read on one edge: occupancy unchanged; both pointers advance. This is legal even when full (read frees the slot) and when empty is not possible (write data appears next cycle; no bypass).
- Full-check uses buf_count only; a simultaneous read does not enable a removal that cycle.
- deq_en deassert in HOLD: no effect until back in IDLE; the in-flight entry is already captured.
- pifo_valid may drop in IDLE because an upstream insert is in progress. The block simply waits; no timeout.

## Timing
- Reset values:
  - pifo_remove = 0, m_valid = 0, m_rank = 0, m_meta = 0.
  - buf_count = 0, deq_count = 0.
  - FSM = IDLE; pointers = 0.
- Reset asserted mid-operation:
  - The FIFO is discarded and the FSM returns to IDLE.
  - The PIFO shares rst domain, so reset causes no spurious removal.
- Latency:
  - remove cycle t: entry visible on m_* with m_valid = 1 at t+1.
  - Minimum consumer-side latency pifo_valid to m_valid: 1 cycle.
- Throughput: at most one removal per 2 cycles (IDLE/HOLD alternation).
- m_* stay stable while m_valid & !m_ready.

## Test plan
- Single entry: PIFO holds rank 5 / meta 0xA1, m_ready = 1 → exactly one pifo_remove pulse; m_rank = 5, m_meta = 0xA1 with m_valid one cycle later; deq_count = 1.
- Sorted drain: PIFO loaded with ranks {9, 3, 7, 1} → output order 1, 3, 7, 9. Remove pulses are spaced at least 2 cycles apart with none in HOLD; deq_count = 4.
- Backpressure: m_ready = 0 with depth 2 and 4 entries → exactly 2 removes, then buf_count = 2 and no further pulses. Raising m_ready drains all 4 in order with no loss or duplication.
- Pause: deq_en = 0 with 3 entries queued → zero pulses. deq_en = 1 for one IDLE cycle, then 0 → exactly one removal.
- Simultaneous read/write at full: buf_count = 2, m_ready = 1, pifo_valid = 1 → no remove that cycle. Remove happens the next cycle; buf_count goes 2 → 1 → 2.
- Async reset at the HOLD cycle with buf_count = 1 → all outputs go to 0 immediately, without a clock edge. After release, operation resumes from IDLE with deq_count = 0.
